// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: derives the 1 MHz and 1 Hz square waves from the 50 MHz CLK.
// It also issues single-cycle strobes aligned to their edges, so CLK-domain consumers
// can use them directly.
// Optional feature: define DIV_RELOAD_EN to make the fast divisor run-time loadable
// through DIV_IN / DIV_LOAD. With it undefined, the fast divisor is the constant FAST_DIV.
module clk_strobe_gen #(
  parameter int FAST_DIV = 50,
  parameter int SLOW_DIV = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       SYNC,
`ifdef DIV_RELOAD_EN
  input  logic [7:0] DIV_IN,
  input  logic       DIV_LOAD,
`endif
  output logic       CLK_1MHz,
  output logic       CLK_1MHz_RE,
  output logic       CLK_1MHz_FE,
  output logic       CLK_1Hz,
  output logic       CLK_1Hz_TICK,
  output logic       RUNNING
);

`ifdef DIV_RELOAD_EN
  localparam int FW = 8;
`else
  localparam int FW = $clog2(FAST_DIV);
`endif
  localparam int SW    = $clog2(SLOW_DIV);
  localparam int SHALF = (SLOW_DIV + 1) / 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [FW-1:0] fcnt, fcnt_next;
  logic [SW-1:0] scnt, scnt_next;
  logic          sync_pend, sync_next, sync_req;
  logic [FW:0]   fdiv_cur, fhalf_next;
  logic          fast_wrap, run_next;

  // The last cycle of a fast period exists only while the counters are running.
  assign fast_wrap = (state != IDLE) && ({1'b0, fcnt} == fdiv_cur - (FW+1)'(1));

  // A SYNC counts only in RUN with EN still high; a falling EN takes precedence.
  assign sync_req  = (state == RUN) && EN && SYNC;

`ifdef DIV_RELOAD_EN
  logic [7:0] div_reg, shadow, load_val, div_next;
  logic       shadow_valid;

  assign load_val   = (DIV_IN < 8'd2) ? 8'd2 : DIV_IN;
  assign fdiv_cur   = {1'b0, div_reg};
  assign fhalf_next = ({1'b0, div_next} + 9'd1) >> 1;

  // Pick the divisor for the next cycle: a pending load is applied only at a period boundary or in IDLE.
  always_comb begin
    div_next = div_reg;
    if ((state == IDLE) || fast_wrap) begin
      if (DIV_LOAD)
        div_next = load_val;
      else if (shadow_valid)
        div_next = shadow;
    end
  end

  // Hold the divisor and its shadow; a load that arrives mid-period waits in the shadow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_reg      <= 8'(FAST_DIV);
      shadow       <= 8'd0;
      shadow_valid <= 1'b0;
    end else begin
      div_reg <= div_next;
      if ((state == IDLE) || fast_wrap) begin
        shadow_valid <= 1'b0;
      end else if (DIV_LOAD) begin
        shadow       <= load_val;
        shadow_valid <= 1'b1;
      end
    end
  end
`else
  assign fdiv_cur   = (FW+1)'(FAST_DIV);
  assign fhalf_next = (FW+1)'((FAST_DIV + 1) / 2);
`endif

  // Next-state and counter logic. The outputs are registered from these next values,
  // so every level and every strobe changes in the same cycle.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    scnt_next  = scnt;
    sync_next  = sync_pend;
    case (state)
      IDLE: begin
        fcnt_next = '0;
        scnt_next = '0;
        sync_next = 1'b0;
        if (EN)
          state_next = RUN;
      end
      RUN, DRAIN: begin
        if (fast_wrap) begin
          fcnt_next = '0;
          sync_next = 1'b0;
          if (sync_pend || sync_req)
            scnt_next = '0;
          else if (scnt == SW'(SLOW_DIV - 1))
            scnt_next = '0;
          else
            scnt_next = scnt + SW'(1);
        end else begin
          fcnt_next = fcnt + FW'(1);
          sync_next = sync_pend || sync_req;
        end
        if ((state == RUN) && !EN) begin
          state_next = DRAIN;
        end else if ((state == DRAIN) && EN) begin
          state_next = RUN;
        end else if ((state == DRAIN) && fast_wrap) begin
          state_next = IDLE;
          fcnt_next  = '0;
          scnt_next  = '0;
          sync_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        fcnt_next  = '0;
        scnt_next  = '0;
        sync_next  = 1'b0;
      end
    endcase
  end

  assign run_next = (state_next != IDLE);

  // State, counters and registered outputs. Every output is zero whenever the next state is IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      fcnt         <= '0;
      scnt         <= '0;
      sync_pend    <= 1'b0;
      CLK_1MHz     <= 1'b0;
      CLK_1MHz_RE  <= 1'b0;
      CLK_1MHz_FE  <= 1'b0;
      CLK_1Hz      <= 1'b0;
      CLK_1Hz_TICK <= 1'b0;
      RUNNING      <= 1'b0;
    end else begin
      state        <= state_next;
      fcnt         <= fcnt_next;
      scnt         <= scnt_next;
      sync_pend    <= sync_next;
      CLK_1MHz     <= run_next && ({1'b0, fcnt_next} < fhalf_next);
      CLK_1MHz_RE  <= run_next && (fcnt_next == '0);
      CLK_1MHz_FE  <= run_next && ({1'b0, fcnt_next} == fhalf_next);
      CLK_1Hz      <= run_next && ({1'b0, scnt_next} < (SW+1)'(SHALF));
      CLK_1Hz_TICK <= run_next && (fcnt_next == '0) && (scnt_next == '0);
      RUNNING      <= run_next;
    end
  end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// tb_clk_strobe_gen: directed bench for clk_strobe_gen with FAST_DIV=50, SLOW_DIV=4.
// Outputs are packed as {RUNNING, CLK_1MHz, RE, FE, CLK_1Hz, TICK}.
// With DIV_RELOAD_EN defined, the divisor-reload sequence is also exercised.
module tb_clk_strobe_gen;
  logic CLK = 1'b0;
  logic RST_N, EN, SYNC;
  logic CLK_1MHz, CLK_1MHz_RE, CLK_1MHz_FE, CLK_1Hz, CLK_1Hz_TICK, RUNNING;
`ifdef DIV_RELOAD_EN
  logic [7:0] DIV_IN;
  logic       DIV_LOAD;
`endif

  int checks = 0;
  int passes = 0;
  int ph     = 0;

  clk_strobe_gen #(.FAST_DIV(50), .SLOW_DIV(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .EN(EN),
    .SYNC(SYNC),
`ifdef DIV_RELOAD_EN
    .DIV_IN(DIV_IN),
    .DIV_LOAD(DIV_LOAD),
`endif
    .CLK_1MHz(CLK_1MHz),
    .CLK_1MHz_RE(CLK_1MHz_RE),
    .CLK_1MHz_FE(CLK_1MHz_FE),
    .CLK_1Hz(CLK_1Hz),
    .CLK_1Hz_TICK(CLK_1Hz_TICK),
    .RUNNING(RUNNING)
  );

  // 50 MHz system clock.
  always #10 CLK = ~CLK;

  function automatic logic [5:0] obsVec();
    return {RUNNING, CLK_1MHz, CLK_1MHz_RE, CLK_1MHz_FE, CLK_1Hz, CLK_1Hz_TICK};
  endfunction

  // Expected outputs while running, for fast position fp, slow position sp and fast divisor fd.
  function automatic logic [5:0] expVec(input int fp, input int sp, input int fd);
    int half;
    half = (fd + 1) / 2;
    return {1'b1, fp < half, fp == 0, fp == half, sp < 2, (fp == 0) && (sp == 0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    if (obs === exp)
      passes++;
    else
      $display("[TB] FAIL %s at t=%0t: got %b expected %b", tag, $time, obs, exp);
  endtask

  task automatic applyStimulus(input logic en, input logic sync);
    EN   = en;
    SYNC = sync;
  endtask

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  // Advance n cycles and compare each one against the undisturbed 50/4 timeline, phase ph.
  task automatic runCheck(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      stepClock();
      ph++;
      checkOutput(tag, obsVec(), expVec(ph % 50, (ph / 50) % 4, 50));
    end
  endtask

  initial begin
    RST_N = 1'b0;
    applyStimulus(1'b0, 1'b0);
`ifdef DIV_RELOAD_EN
    DIV_IN   = 8'd0;
    DIV_LOAD = 1'b0;
`endif
    #2;
    checkOutput("reset_state", obsVec(), 6'b000000);
    stepClock();
    stepClock();
    RST_N = 1'b1;
    stepClock();
    checkOutput("idle_after_reset", obsVec(), 6'b000000);

    // Startup: the first running cycle shows every rising strobe.
    $display("[TB] basic free-running timeline");
    applyStimulus(1'b1, 1'b0);
    stepClock();
    ph = 0;
    checkOutput("first_run_cycle", obsVec(), 6'b111011);
    runCheck(410, "free_run");

    // Stop at fcnt=10: drain to the end of the fast period, then go idle.
    $display("[TB] drain to idle");
    applyStimulus(1'b0, 1'b0);
    runCheck(39, "drain");
    for (int i = 0; i < 10; i++) begin
      stepClock();
      checkOutput("idle_after_drain", obsVec(), 6'b000000);
    end
    applyStimulus(1'b0, 1'b1);
    stepClock();
    checkOutput("sync_in_idle", obsVec(), 6'b000000);
    applyStimulus(1'b0, 1'b0);
    stepClock();
    checkOutput("sync_in_idle_after", obsVec(), 6'b000000);

    // Restart, then toggle EN during DRAIN: the timeline must stay undisturbed.
    $display("[TB] EN toggle during drain");
    applyStimulus(1'b1, 1'b0);
    stepClock();
    ph = 0;
    checkOutput("restart_first", obsVec(), 6'b111011);
    runCheck(60, "pre_toggle");
    applyStimulus(1'b0, 1'b0);
    runCheck(5, "toggle_drain");
    applyStimulus(1'b1, 1'b0);
    runCheck(235, "toggle_resume");

    // SYNC at scnt=1, fcnt=5 (ph=455): the slow phase restarts at ph=500.
    $display("[TB] sync restart");
    runCheck(155, "pre_sync");
    applyStimulus(1'b1, 1'b1);
    runCheck(1, "sync_pulse");
    applyStimulus(1'b1, 1'b0);
    runCheck(43, "sync_pending");
    ph = -1;
    runCheck(201, "post_sync");

    // Asynchronous reset between clock edges during a high phase.
    $display("[TB] async reset mid phase");
    #3;
    RST_N = 1'b0;
    #1;
    checkOutput("async_reset_immediate", obsVec(), 6'b000000);
    stepClock();
    checkOutput("async_reset_held", obsVec(), 6'b000000);
    RST_N = 1'b1;
    ph = -1;
    runCheck(104, "after_reset");

`ifdef DIV_RELOAD_EN
    // Load 10 at fcnt=3: the current 50-cycle period completes, then 5 high / 5 low.
    $display("[TB] divisor reload");
    DIV_IN   = 8'd10;
    DIV_LOAD = 1'b1;
    runCheck(1, "load_cycle");
    DIV_LOAD = 1'b0;
    runCheck(45, "load_pending");
    for (int j = 0; j < 60; j++) begin
      stepClock();
      checkOutput("div10", obsVec(), expVec(j % 10, (3 + j / 10) % 4, 10));
      if (j == 53) begin
        DIV_IN   = 8'd1;
        DIV_LOAD = 1'b1;
      end else begin
        DIV_LOAD = 1'b0;
      end
    end
    for (int m = 0; m < 20; m++) begin
      stepClock();
      checkOutput("div2_clamped", obsVec(), expVec(m % 2, (1 + m / 2) % 4, 2));
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
